// File: rtl/mesa_uart_tx_fifo_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : mesa_uart_tx_fifo_if                                          |
// | Purpose  : Byte-strobe and status bundle between a MesaBus byte source    |
// |            and the buffered UART transmitter.                             |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
interface mesa_uart_tx_fifo_if #(
  parameter int FIFO_AW = 4
) ();
  logic             tx_byte_en;
  logic [7:0]       tx_byte_d;
  logic             tx_busy;
  logic             tx_idle;
  logic             tx_ovfl;
  logic [FIFO_AW:0] fifo_lvl;

  // Byte source: strobes bytes in and watches back-pressure/status
  modport master (
    output tx_byte_en,
    output tx_byte_d,
    input  tx_busy,
    input  tx_idle,
    input  tx_ovfl,
    input  fifo_lvl
  );

  // Transmitter side
  modport slave (
    input  tx_byte_en,
    input  tx_byte_d,
    output tx_busy,
    output tx_idle,
    output tx_ovfl,
    output fifo_lvl
  );
endinterface
`default_nettype wire

// File: rtl/mesa_uart_tx_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : mesa_uart_tx_fifo                                             |
// | Purpose  : Buffered UART transmitter. Bytes strobed in on the bus side    |
// |            are queued in a small FIFO and serialised LSB first on ser_tx  |
// |            (8N1 by default). tx_busy gives early back-pressure, tx_ovfl   |
// |            latches any push that arrives while the FIFO is full.          |
// | Options  : define MESA_UART_TX_PARITY_EN for an even-parity bit (8E1).    |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module mesa_uart_tx_fifo #(
  parameter int BAUD_DIV  = 25,  // clocks per serial bit, 4..255
  parameter int FIFO_AW   = 4,   // FIFO depth is 2**FIFO_AW
  parameter int AFULL_LVL = 12   // occupancy at which tx_busy asserts
) (
  input  logic               clk,
  input  logic               reset_l,
  mesa_uart_tx_fifo_if.slave bus,
  output logic               ser_tx
);

  localparam int unsigned        c_depth_i   = 2 ** FIFO_AW;
  localparam logic [FIFO_AW:0]   c_depth     = {1'b1, {FIFO_AW{1'b0}}};
  localparam logic [FIFO_AW:0]   c_afull     = (FIFO_AW + 1)'(AFULL_LVL);
  localparam logic [FIFO_AW:0]   c_lvl_one   = (FIFO_AW + 1)'(1);
  localparam logic [FIFO_AW-1:0] c_ptr_one   = (FIFO_AW)'(1);
  localparam logic [7:0]         c_bcnt_last = 8'(BAUD_DIV - 1);
  localparam logic [2:0]         c_bidx_last = 3'd7;

`ifdef MESA_UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_STOP   = 3'd4
  } state_t;
`endif

  // FIFO storage and bookkeeping
  logic [7:0]         r_mem [c_depth_i];
  logic [FIFO_AW-1:0] r_wptr;
  logic [FIFO_AW-1:0] r_rptr;
  logic [FIFO_AW:0]   r_lvl;

  // Registered status
  logic               r_busy;
  logic               r_idle;
  logic               r_ovfl;

  // Serialiser
  state_t             r_state;
  logic [7:0]         r_bcnt;
  logic [2:0]         r_bidx;
  logic [7:0]         r_shift;
  logic               r_ser;
`ifdef MESA_UART_TX_PARITY_EN
  logic               r_par;
`endif

  // Combinational helpers
  logic               w_full;
  logic               w_empty;
  logic               w_push;
  logic               w_pop;
  logic               w_bit_end;
  logic               w_fsm_to_idle;
  logic [FIFO_AW:0]   w_lvl_nxt;
  logic [7:0]         w_rd_data;

  // Push/pop decisions. Full is judged on the current level, so a push that
  // meets a full FIFO is lost even if the serialiser pops in the same cycle.
  always_comb begin
    w_full        = (r_lvl == c_depth);
    w_empty       = (r_lvl == '0);
    w_bit_end     = (r_bcnt == c_bcnt_last);
    w_push        = bus.tx_byte_en && !w_full;
    // The serialiser takes a byte from IDLE or at the very end of a stop bit
    w_pop         = !w_empty && ((r_state == S_IDLE) ||
                                 ((r_state == S_STOP) && w_bit_end));
    // With nothing queued the FSM rests (or lands) in IDLE after this edge
    w_fsm_to_idle = w_empty && ((r_state == S_IDLE) ||
                                ((r_state == S_STOP) && w_bit_end));
    w_rd_data     = r_mem[r_rptr];
    w_lvl_nxt     = r_lvl;
    if (w_push && !w_pop) begin
      w_lvl_nxt = r_lvl + c_lvl_one;
    end else if (w_pop && !w_push) begin
      w_lvl_nxt = r_lvl - c_lvl_one;
    end
  end

  // FIFO data array; no reset needed since the level gates every read
  always_ff @(posedge clk) begin
    if (reset_l && w_push) begin
      r_mem[r_wptr] <= bus.tx_byte_d;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at the depth
  always_ff @(posedge clk) begin
    if (!reset_l) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_lvl  <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + c_ptr_one;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + c_ptr_one;
      end
      r_lvl <= w_lvl_nxt;
    end
  end

  // Status flags follow the level and state as they will be after this edge
  always_ff @(posedge clk) begin
    if (!reset_l) begin
      r_busy <= 1'b0;
      r_idle <= 1'b1;
      r_ovfl <= 1'b0;
    end else begin
      r_busy <= (w_lvl_nxt >= c_afull);
      r_idle <= (w_lvl_nxt == '0) && w_fsm_to_idle;
      r_ovfl <= r_ovfl | (bus.tx_byte_en && w_full);
    end
  end

  // Serialiser FSM: frame sequencing with the line level registered alongside
  always_ff @(posedge clk) begin
    if (!reset_l) begin
      r_state <= S_IDLE;
      r_ser   <= 1'b1;
      r_bcnt  <= '0;
      r_bidx  <= '0;
      r_shift <= '0;
`ifdef MESA_UART_TX_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          r_ser <= 1'b1;
          if (w_pop) begin
            r_shift <= w_rd_data;
`ifdef MESA_UART_TX_PARITY_EN
            r_par   <= ^w_rd_data;
`endif
            r_bcnt  <= '0;
            r_state <= S_START;
            r_ser   <= 1'b0;
          end
        end

        S_START: begin
          if (w_bit_end) begin
            r_bcnt  <= '0;
            r_bidx  <= '0;
            r_state <= S_DATA;
            r_ser   <= r_shift[0];
          end else begin
            r_bcnt <= r_bcnt + 8'd1;
          end
        end

        S_DATA: begin
          if (w_bit_end) begin
            r_bcnt <= '0;
            if (r_bidx == c_bidx_last) begin
`ifdef MESA_UART_TX_PARITY_EN
              r_state <= S_PARITY;
              r_ser   <= r_par;
`else
              r_state <= S_STOP;
              r_ser   <= 1'b1;
`endif
            end else begin
              // Shift right so the next data bit always sits at bit 1
              r_bidx  <= r_bidx + 3'd1;
              r_shift <= {1'b0, r_shift[7:1]};
              r_ser   <= r_shift[1];
            end
          end else begin
            r_bcnt <= r_bcnt + 8'd1;
          end
        end

`ifdef MESA_UART_TX_PARITY_EN
        S_PARITY: begin
          if (w_bit_end) begin
            r_bcnt  <= '0;
            r_state <= S_STOP;
            r_ser   <= 1'b1;
          end else begin
            r_bcnt <= r_bcnt + 8'd1;
          end
        end
`endif

        S_STOP: begin
          if (w_bit_end) begin
            r_bcnt <= '0;
            if (w_pop) begin
              // Back-to-back frame: next start bit follows the stop bit directly
              r_shift <= w_rd_data;
`ifdef MESA_UART_TX_PARITY_EN
              r_par   <= ^w_rd_data;
`endif
              r_state <= S_START;
              r_ser   <= 1'b0;
            end else begin
              r_state <= S_IDLE;
              r_ser   <= 1'b1;
            end
          end else begin
            r_bcnt <= r_bcnt + 8'd1;
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_ser   <= 1'b1;
          r_bcnt  <= '0;
        end
      endcase
    end
  end

  assign ser_tx       = r_ser;
  assign bus.tx_busy  = r_busy;
  assign bus.tx_idle  = r_idle;
  assign bus.tx_ovfl  = r_ovfl;
  assign bus.fifo_lvl = r_lvl;

endmodule
`default_nettype wire
